// File: rtl/trap_sequencer.sv
// trap_sequencer: arbitrates synchronous exceptions, pending interrupts and
// mret, drives the machine-mode trap/xret CSR update ports, then flushes the
// pipeline and redirects fetch to the trap handler or to mepc.
//
// Optional feature: define TRAP_VECTORED_MTVEC_EN to honour mtvec mode 1
// (vectored) for interrupts. Without it every trap goes to the mtvec base.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | normal execution, watching for exception / mret / interrupt
// DRAIN    | interrupt pending, issue held until the pipeline is empty
// TRAP     | one cycle: trap CSR update + flush
// XRET     | one cycle: mret CSR update + flush
// REDIRECT | redirect offered to fetch until accepted

`ifndef XLEN
`define XLEN 64
`endif
`ifndef ALEN
`define ALEN 64
`endif
`ifndef PLATFORM_INTR_LEN
`define PLATFORM_INTR_LEN 16
`endif
`ifndef INTR_LEN
`define INTR_LEN (16 + `PLATFORM_INTR_LEN)
`endif

module trap_sequencer (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 exc_valid,
  input  logic [3:0]           exc_cause,
  input  logic [`ALEN-1:0]     exc_pc,
  input  logic [`XLEN-1:0]     exc_tval,
  input  logic                 mret_valid,
  input  logic                 pipe_empty,
  input  logic [`ALEN-1:0]     resume_pc,
  input  logic [`XLEN-1:0]     mstatus,
  input  logic [`INTR_LEN-1:0] mie,
  input  logic [`INTR_LEN-1:0] mip,
  input  logic [`XLEN-1:0]     mtvec,
  input  logic [`ALEN-1:0]     mepc,
  input  logic [1:0]           privilege_mode,
  input  logic                 redirect_ready,
  output logic                 trap_do_update,
  output logic [`XLEN-1:0]     trap_mcause,
  output logic [`ALEN-1:0]     trap_mepc,
  output logic [`XLEN-1:0]     trap_mtval,
  output logic                 xret_do_update,
  output logic                 xret_completing,
  output logic [`XLEN-1:0]     xret_new_mstatus,
  output logic [1:0]           xret_new_privilege_mode,
  output logic                 issue_hold,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [`ALEN-1:0]     redirect_pc
);

  localparam int CW = $clog2(`INTR_LEN);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DRAIN    = 3'd1,
    S_TRAP     = 3'd2,
    S_XRET     = 3'd3,
    S_REDIRECT = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [`XLEN-1:0]    r_mcause;
  logic [`ALEN-1:0]    r_mepc;
  logic [`XLEN-1:0]    r_mtval;
  logic [`ALEN-1:0]    r_redirect_pc;
  logic                r_is_intr;
  logic [CW-1:0]       r_code;

  logic [`INTR_LEN-1:0] w_pend;
  logic                w_intr_pending;
  logic [CW-1:0]       w_intr_code;
  logic [`XLEN-1:0]    w_trap_target;
  logic [`XLEN-1:0]    w_mstatus_ret;
  logic                w_take_exc;
  logic                w_take_intr;
  logic                w_unused;

  assign w_pend         = mip & mie;
  assign w_intr_pending = (|w_pend) && (mstatus[3] || (privilege_mode < 2'd3));

  // Interrupt code: highest platform bit, then MTI. Any other standard bit
  // (not expected to be wired) falls back to the highest one set so a
  // pending interrupt always has a defined code.
  always_comb begin
    w_intr_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (w_pend[i]) w_intr_code = CW'(i);
    end
    if (w_pend[7]) w_intr_code = CW'(7);
    for (int i = 16; i < `INTR_LEN; i++) begin
      if (w_pend[i]) w_intr_code = CW'(i);
    end
  end

  // Handler address for the trap being taken.
  always_comb begin
    w_trap_target = {mtvec[`XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_MTVEC_EN
    if (r_is_intr && (mtvec[1:0] == 2'b01)) begin
      w_trap_target = {mtvec[`XLEN-1:2], 2'b00} + (`XLEN'(r_code) << 2);
    end
`endif
  end

  // mstatus after mret: MIE <- MPIE, MPIE <- 1, MPP <- M.
  always_comb begin
    w_mstatus_ret        = mstatus;
    w_mstatus_ret[3]     = mstatus[7];
    w_mstatus_ret[7]     = 1'b1;
    w_mstatus_ret[12:11] = 2'b11;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and per-state outputs. An mret committing during DRAIN is
  // honoured rather than lost; the interrupt is re-evaluated afterwards.
  // Issue stays held from DRAIN until the redirect is accepted.
  always_comb begin
    w_state_nxt             = r_state;
    trap_do_update          = 1'b0;
    xret_do_update          = 1'b0;
    xret_completing         = 1'b0;
    xret_new_mstatus        = '0;
    xret_new_privilege_mode = 2'b00;
    issue_hold              = 1'b0;
    flush                   = 1'b0;
    redirect_valid          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (exc_valid)           w_state_nxt = S_TRAP;
        else if (mret_valid)     w_state_nxt = S_XRET;
        else if (w_intr_pending) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        issue_hold = 1'b1;
        if (exc_valid)       w_state_nxt = S_TRAP;
        else if (mret_valid) w_state_nxt = S_XRET;
        else if (pipe_empty) w_state_nxt = w_intr_pending ? S_TRAP : S_IDLE;
      end
      S_TRAP: begin
        trap_do_update = 1'b1;
        flush          = 1'b1;
        issue_hold     = 1'b1;
        w_state_nxt    = S_REDIRECT;
      end
      S_XRET: begin
        xret_do_update          = 1'b1;
        xret_completing         = 1'b1;
        xret_new_mstatus        = w_mstatus_ret;
        xret_new_privilege_mode = mstatus[12:11];
        flush                   = 1'b1;
        issue_hold              = 1'b1;
        w_state_nxt             = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        issue_hold     = 1'b1;
        if (redirect_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_take_exc  = ((r_state == S_IDLE) || (r_state == S_DRAIN)) && exc_valid;
  assign w_take_intr = (r_state == S_DRAIN) && (w_state_nxt == S_TRAP) && !exc_valid;

  // Trap record capture and redirect target latch (held stable in REDIRECT).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcause      <= '0;
      r_mepc        <= '0;
      r_mtval       <= '0;
      r_redirect_pc <= '0;
      r_is_intr     <= 1'b0;
      r_code        <= '0;
    end else begin
      if (w_take_exc) begin
        r_mcause  <= {{(`XLEN-4){1'b0}}, exc_cause};
        r_mepc    <= exc_pc;
        r_mtval   <= exc_tval;
        r_is_intr <= 1'b0;
      end else if (w_take_intr) begin
        r_mcause  <= {1'b1, {(`XLEN-1-CW){1'b0}}, w_intr_code};
        r_mepc    <= resume_pc;
        r_mtval   <= '0;
        r_is_intr <= 1'b1;
        r_code    <= w_intr_code;
      end
      if (r_state == S_TRAP)      r_redirect_pc <= w_trap_target[`ALEN-1:0];
      else if (r_state == S_XRET) r_redirect_pc <= mepc;
    end
  end

  assign trap_mcause = r_mcause;
  assign trap_mepc   = r_mepc;
  assign trap_mtval  = r_mtval;
  assign redirect_pc = r_redirect_pc;

  // Mode bits and interrupt code only matter in the vectored build.
  assign w_unused = ^{mtvec[1:0], r_is_intr, r_code};

endmodule
